// File: rtl/pause_responder.sv
// CPU-side end of the pause handshake: divides clk_sys into cpu_ce, halts the CPU at a
// vblank-aligned instruction boundary (or after a drain timeout) and restarts on a frame edge.
module pause_responder #(
  parameter int CE_DIV    = 12,
  parameter int SAFE_WAIT = 400000,
  parameter int FCW       = 16
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           pause_req,
  input  logic           vblank,
  input  logic           bus_idle,
  output logic           cpu_ce,
  output logic           paused,
  output logic           audio_mute,
  output logic           resume_pulse,
  output logic [FCW-1:0] paused_frames,
  output logic           forced
);

  localparam int DIV_W = $clog2(CE_DIV);
  localparam int TMR_W = $clog2(SAFE_WAIT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(SAFE_WAIT);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT,
    ST_RESUME
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [FCW-1:0]   frames_q, frames_d;
  logic             vblank_q, vblank_d;
  logic             pending_q, pending_d;
  logic             forced_q, forced_d;
  logic             resume_arm_q, resume_arm_d;

  logic vb_rise;
  logic div_last;
  logic run_ce;
  logic halt_ok;
  logic timeout;

  // NOTE: every variable assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    vb_rise      = vblank & ~vblank_q;
    div_last     = (div_q == DIV_LAST);
    halt_ok      = (pending_q | vb_rise) & div_last & bus_idle;
    timeout      = (timer_q == TMR_MAX) & div_last;

    state_d      = state_q;
    div_d        = div_last ? '0 : div_q + 1'b1;
    timer_d      = timer_q;
    frames_d     = frames_q;
    vblank_d     = vblank;
    pending_d    = pending_q;
    forced_d     = forced_q;
    resume_arm_d = resume_arm_q;
    run_ce       = 1'b0;

    case (state_q)
      ST_RUN: begin
        run_ce    = div_last;
        timer_d   = '0;
        pending_d = 1'b0;
        if (pause_req) begin
          state_d  = ST_DRAIN;
          frames_d = '0;
        end
      end
      ST_DRAIN: begin
        run_ce  = div_last;
        timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
        if (vb_rise) pending_d = 1'b1;
        // A cooperative halt point beats both the timeout and a request that just dropped.
        if (halt_ok) begin
          state_d   = ST_HALT;
          forced_d  = 1'b0;
          pending_d = 1'b0;
        end else if (timeout) begin
          state_d   = ST_HALT;
          forced_d  = 1'b1;
          pending_d = 1'b0;
        end else if (!pause_req) begin
          state_d   = ST_RUN;
          pending_d = 1'b0;
        end
      end
      ST_HALT: begin
        div_d = '0;
        if (vb_rise && !(&frames_q)) frames_d = frames_q + 1'b1;
        if (!pause_req) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        div_d = '0;
        if (pause_req) begin
          state_d = ST_HALT;
        end else if (vb_rise) begin
          state_d      = ST_RUN;
          resume_arm_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        div_d   = '0;
      end
    endcase

    if (run_ce) resume_arm_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_RUN;
      div_q        <= '0;
      timer_q      <= '0;
      frames_q     <= '0;
      vblank_q     <= 1'b0;
      pending_q    <= 1'b0;
      forced_q     <= 1'b0;
      resume_arm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      timer_q      <= timer_d;
      frames_q     <= frames_d;
      vblank_q     <= vblank_d;
      pending_q    <= pending_d;
      forced_q     <= forced_d;
      resume_arm_q <= resume_arm_d;
    end
  end

  assign cpu_ce        = run_ce;
  assign paused        = (state_q == ST_HALT) || (state_q == ST_RESUME);
  assign audio_mute    = (state_q == ST_HALT);
  assign resume_pulse  = resume_arm_q & run_ce;
  assign paused_frames = frames_q;
  assign forced        = forced_q;

endmodule

// File: tb/tb_pause_responder.sv
// Scoreboard bench for pause_responder: two instances (FCW=16 and FCW=2) share stimulus;
// expected cpu_ce events and status snapshots are queued ahead and popped by a monitor.
module tb_pause_responder;

  logic        clk_sys;
  logic        reset;
  logic        pause_req;
  logic        vblank;
  logic        bus_idle;
  logic        cpu_ce, paused, audio_mute, resume_pulse, forced;
  logic [15:0] paused_frames;
  logic        cpu_ce_b, paused_b, audio_mute_b, resume_pulse_b, forced_b;
  logic [1:0]  paused_frames_b;

  pause_responder #(.CE_DIV(12), .SAFE_WAIT(1000), .FCW(16)) dut (
    .clk_sys(clk_sys), .reset(reset), .pause_req(pause_req), .vblank(vblank),
    .bus_idle(bus_idle), .cpu_ce(cpu_ce), .paused(paused), .audio_mute(audio_mute),
    .resume_pulse(resume_pulse), .paused_frames(paused_frames), .forced(forced)
  );

  pause_responder #(.CE_DIV(12), .SAFE_WAIT(1000), .FCW(2)) dut_sat (
    .clk_sys(clk_sys), .reset(reset), .pause_req(pause_req), .vblank(vblank),
    .bus_idle(bus_idle), .cpu_ce(cpu_ce_b), .paused(paused_b), .audio_mute(audio_mute_b),
    .resume_pulse(resume_pulse_b), .paused_frames(paused_frames_b), .forced(forced_b)
  );

  typedef struct {
    int   cyc;
    logic rp;
  } ce_ev_t;

  typedef struct {
    int          cyc;
    string       name;
    logic [27:0] exp;
  } snap_t;

  ce_ev_t ce_q[$];
  snap_t  snap_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     t0 = 0;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic push_snap(input int c, input string n, input logic ce, input logic p,
                           input logic m, input logic rp, input logic f,
                           input logic [15:0] fr, input logic [1:0] frb);
    snap_t s;
    s.cyc  = c;
    s.name = n;
    s.exp  = {ce, p, m, rp, f, ce, p, m, rp, f, fr, frb};
    snap_q.push_back(s);
  endtask

  task automatic push_ce(input int first, input int last, input logic rp_first);
    for (int t = first; t <= last; t += 12) begin
      ce_ev_t e;
      e.cyc = t;
      e.rp  = (t == first) ? rp_first : 1'b0;
      ce_q.push_back(e);
    end
  endtask

  // Two reset edges; t0 is the first cycle with reset released (div=0, RUN).
  task automatic do_reset(input string tag);
    reset     = 1'b1;
    pause_req = 1'b0;
    vblank    = 1'b0;
    bus_idle  = 1'b0;
    push_snap(cyc + 1, {"reset_", tag}, 0, 0, 0, 0, 0, 16'd0, 2'd0);
    step(2);
    reset = 1'b0;
    t0    = cyc;
  endtask

  // Monitor: every cpu_ce pulse must match the next queued event; snapshots compare on their cycle.
  always @(negedge clk_sys) begin
    if (!reset && cpu_ce) begin
      if (ce_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ce_unexpected at cycle %0d: got cpu_ce=1 expected no pulse", cyc);
      end else begin
        ce_ev_t e;
        e = ce_q.pop_front();
        check("ce_cycle", cyc, e.cyc);
        check("ce_resume_pulse", resume_pulse, e.rp);
      end
    end
    if (!reset && resume_pulse && !cpu_ce) begin
      checks++;
      errors++;
      $display("FAIL resume_without_ce at cycle %0d: got resume_pulse=1 expected 0", cyc);
    end
    while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
      snap_t s;
      s = snap_q.pop_front();
      check(s.name, {cpu_ce, paused, audio_mute, resume_pulse, forced,
                     cpu_ce_b, paused_b, audio_mute_b, resume_pulse_b, forced_b,
                     paused_frames, paused_frames_b}, s.exp);
    end
  end

  initial begin
    reset     = 1'b1;
    pause_req = 1'b0;
    vblank    = 1'b0;
    bus_idle  = 1'b0;

    // Free run: cpu_ce every 12th cycle, everything else quiet.
    do_reset("s1");
    push_snap(t0, "s1_idle", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 11, "s1_first_ce", 1, 0, 0, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 12, "s1_after_ce", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    push_ce(t0 + 11, t0 + 119, 1'b0);
    wait_until(t0 + 125);

    // Cooperative halt on vblank, three frames halted, release on next vblank.
    do_reset("s2");
    push_ce(t0 + 11, t0 + 515, 1'b0);
    push_ce(t0 + 632, t0 + 692, 1'b1);
    push_snap(t0 + 515, "s2_final_ce", 1, 0, 0, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 516, "s2_halt_entry", 0, 1, 1, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 590, "s2_three_frames", 0, 1, 1, 0, 0, 16'd3, 2'd3);
    push_snap(t0 + 601, "s2_resume_unmute", 0, 1, 0, 0, 0, 16'd3, 2'd3);
    push_snap(t0 + 620, "s2_resume_hold", 0, 1, 0, 0, 0, 16'd3, 2'd3);
    push_snap(t0 + 621, "s2_run_again", 0, 0, 0, 0, 0, 16'd3, 2'd3);
    push_snap(t0 + 632, "s2_resume_pulse", 1, 0, 0, 1, 0, 16'd3, 2'd3);
    push_snap(t0 + 633, "s2_pulse_one_cycle", 0, 0, 0, 0, 0, 16'd3, 2'd3);
    wait_until(t0 + 5);
    pause_req = 1'b1;
    bus_idle  = 1'b1;
    wait_until(t0 + 505); vblank = 1'b1;
    wait_until(t0 + 520); vblank = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_until(t0 + 540 + 20 * k); vblank = 1'b1;
      wait_until(t0 + 545 + 20 * k); vblank = 1'b0;
    end
    wait_until(t0 + 600); pause_req = 1'b0;
    wait_until(t0 + 620); vblank = 1'b1;
    wait_until(t0 + 625); vblank = 1'b0;
    wait_until(t0 + 700);

    // Forced halt after SAFE_WAIT, then a cooperative halt clears forced; reset while halted.
    do_reset("s3");
    push_ce(t0 + 11, t0 + 1007, 1'b0);
    push_ce(t0 + 1032, t0 + 1056, 1'b1);
    push_snap(t0 + 1007, "s3_last_ce", 1, 0, 0, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 1008, "s3_forced_halt", 0, 1, 1, 0, 1, 16'd0, 2'd0);
    push_snap(t0 + 1011, "s3_resume", 0, 1, 0, 0, 1, 16'd0, 2'd0);
    push_snap(t0 + 1025, "s3_forced_sticky", 0, 0, 0, 0, 1, 16'd0, 2'd0);
    push_snap(t0 + 1032, "s3_resume_pulse", 1, 0, 0, 1, 1, 16'd0, 2'd0);
    push_snap(t0 + 1057, "s3_clean_halt", 0, 1, 1, 0, 0, 16'd0, 2'd0);
    wait_until(t0 + 5);    pause_req = 1'b1;
    wait_until(t0 + 1010); pause_req = 1'b0;
    wait_until(t0 + 1020); vblank = 1'b1;
    wait_until(t0 + 1025); vblank = 1'b0;
    wait_until(t0 + 1030); pause_req = 1'b1; bus_idle = 1'b1;
    wait_until(t0 + 1050); vblank = 1'b1;
    wait_until(t0 + 1055); vblank = 1'b0;
    wait_until(t0 + 1070);

    // Short request with no vblank: back to RUN, cadence unbroken; reset while draining.
    do_reset("s5");
    push_ce(t0 + 11, t0 + 259, 1'b0);
    push_snap(t0 + 100, "s5_drain_running", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 210, "s5_back_to_run", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 255, "s5_drain_again", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    wait_until(t0 + 5);   pause_req = 1'b1; bus_idle = 1'b1;
    wait_until(t0 + 205); pause_req = 1'b0;
    wait_until(t0 + 250); pause_req = 1'b1;
    wait_until(t0 + 260);

    // vblank rise, halt point and request release all on the same cycle.
    do_reset("s6");
    push_ce(t0 + 11, t0 + 23, 1'b0);
    push_snap(t0 + 24, "s6_halt_wins", 0, 1, 1, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 25, "s6_then_resume", 0, 1, 0, 0, 0, 16'd0, 2'd0);
    wait_until(t0 + 2);  pause_req = 1'b1; bus_idle = 1'b1;
    wait_until(t0 + 23); vblank = 1'b1; pause_req = 1'b0;
    wait_until(t0 + 30); vblank = 1'b0;
    wait_until(t0 + 40);

    // Five frames halted: 16-bit counter reads 5, 2-bit counter saturates at 3.
    do_reset("s7");
    push_ce(t0 + 11, t0 + 23, 1'b0);
    push_ce(t0 + 162, t0 + 174, 1'b1);
    push_snap(t0 + 24, "s7_halt", 0, 1, 1, 0, 0, 16'd0, 2'd0);
    push_snap(t0 + 85, "s7_three_frames", 0, 1, 1, 0, 0, 16'd3, 2'd3);
    push_snap(t0 + 105, "s7_four_frames", 0, 1, 1, 0, 0, 16'd4, 2'd3);
    push_snap(t0 + 130, "s7_five_frames", 0, 1, 1, 0, 0, 16'd5, 2'd3);
    push_snap(t0 + 136, "s7_resume", 0, 1, 0, 0, 0, 16'd5, 2'd3);
    push_snap(t0 + 151, "s7_run", 0, 0, 0, 0, 0, 16'd5, 2'd3);
    push_snap(t0 + 162, "s7_resume_pulse", 1, 0, 0, 1, 0, 16'd5, 2'd3);
    push_snap(t0 + 171, "s7_frames_cleared", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    wait_until(t0 + 5);  pause_req = 1'b1; bus_idle = 1'b1;
    wait_until(t0 + 20); vblank = 1'b1;
    wait_until(t0 + 25); vblank = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_until(t0 + 40 + 20 * k); vblank = 1'b1;
      wait_until(t0 + 45 + 20 * k); vblank = 1'b0;
    end
    wait_until(t0 + 135); pause_req = 1'b0;
    wait_until(t0 + 150); vblank = 1'b1;
    wait_until(t0 + 155); vblank = 1'b0;
    wait_until(t0 + 170); pause_req = 1'b1;
    wait_until(t0 + 180);

    // After a reset in DRAIN the CPU runs again with cpu_ce 12 cycles later.
    do_reset("final");
    push_ce(t0 + 11, t0 + 23, 1'b0);
    push_snap(t0 + 12, "final_run", 0, 0, 0, 0, 0, 16'd0, 2'd0);
    wait_until(t0 + 30);

    check("ce_events_outstanding", ce_q.size(), 0);
    check("snapshots_outstanding", snap_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
